// File: rtl/param_stream_tx.sv
// param_stream_tx: takes parameter bytes over valid/ready and shifts them MSB-first, one acknowledged bit at a time,
// into the parameter memory. Optional acknowledge watchdog is enabled by defining PARAM_TX_TIMEOUT_EN.
module param_stream_tx #(
  parameter int NUM_BITS = 312,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       data_out,
  output logic       load_params,
  input  logic       data_written,
  input  logic       end_writing,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] bit_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BYTE = 3'd2,
    SHIFT     = 3'd3,
    WAIT_END  = 3'd4,
    ERROR     = 3'd5
  } state_e;

  localparam logic [8:0] LAST_COUNT = 9'(NUM_BITS);

  // Reject configurations the 9-bit counter or 8-bit watchdog cannot represent.
  generate
    if (((NUM_BITS % 8) != 0) || (NUM_BITS < 8) || (NUM_BITS > 511) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_cfg
      $error("param_stream_tx: unsupported NUM_BITS/TIMEOUT");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [8:0] bit_count_q, bit_count_d;
  logic       data_out_q, data_out_d;
  logic       load_params_q, load_params_d;
  logic       byte_ready_q, byte_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       accept_s;
  logic       ack_s;
  logic       final_s;
  logic       timeout_s;
  logic [8:0] count_inc_s;

  assign accept_s    = (state_q == WAIT_BYTE) && byte_valid && byte_ready_q;
  assign ack_s       = (state_q == SHIFT) && data_written;
  assign count_inc_s = (bit_count_q < LAST_COUNT) ? (bit_count_q + 9'd1) : bit_count_q;
  assign final_s     = ack_s && (count_inc_s == LAST_COUNT);

`ifdef PARAM_TX_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

  logic [7:0] wdog_q, wdog_d;
  logic       waiting_s;

  assign waiting_s = ((state_q == SHIFT) && !data_written) || ((state_q == WAIT_END) && !end_writing);
  assign timeout_s = waiting_s && (({1'b0, wdog_q} + 9'd1) >= TIMEOUT_LIMIT);

  // Watchdog restarts on every acknowledge and whenever no acknowledge is awaited.
  always_comb begin
    wdog_d = 8'd0;
    if (waiting_s) begin
      wdog_d = wdog_q + 8'd1;
    end else begin
      wdog_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= 8'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= 8'd0;
      bit_idx_q     <= 3'd0;
      bit_count_q   <= 9'd0;
      data_out_q    <= 1'b0;
      load_params_q <= 1'b0;
      byte_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_idx_q     <= bit_idx_d;
      bit_count_q   <= bit_count_d;
      data_out_q    <= data_out_d;
      load_params_q <= load_params_d;
      byte_ready_q  <= byte_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Next-state logic; a final acknowledge wins over a simultaneous end_writing.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
        else       state_d = IDLE;
      end
      LOAD: begin
        if (end_writing || data_written) state_d = ERROR;
        else                             state_d = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (end_writing || data_written) state_d = ERROR;
        else if (accept_s)               state_d = SHIFT;
        else                             state_d = WAIT_BYTE;
      end
      SHIFT: begin
        if (final_s)                          state_d = WAIT_END;
        else if (end_writing || timeout_s)    state_d = ERROR;
        else if (ack_s && (bit_idx_q == 3'd7)) state_d = WAIT_BYTE;
        else                                  state_d = SHIFT;
      end
      WAIT_END: begin
        if (data_written) begin
          state_d = ERROR;
        end else if (end_writing) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timeout_s) begin
          state_d = ERROR;
        end else begin
          state_d = WAIT_END;
        end
      end
      ERROR: begin
        if (start) state_d = LOAD;
        else       state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register and counters.
  always_comb begin
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    bit_count_d = bit_count_q;
    if (((state_q == IDLE) || (state_q == ERROR)) && start) begin
      bit_count_d = 9'd0;
      bit_idx_d   = 3'd0;
    end else if (accept_s) begin
      shreg_d   = byte_in;
      bit_idx_d = 3'd0;
    end else if (ack_s) begin
      shreg_d     = {shreg_q[6:0], 1'b0};
      bit_idx_d   = bit_idx_q + 3'd1;
      bit_count_d = count_inc_s;
    end else begin
      shreg_d     = shreg_q;
      bit_idx_d   = bit_idx_q;
      bit_count_d = bit_count_q;
    end
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    load_params_d = (state_d == LOAD);
    byte_ready_d  = (state_d == WAIT_BYTE);
    busy_d        = (state_d == LOAD) || (state_d == WAIT_BYTE) ||
                    (state_d == SHIFT) || (state_d == WAIT_END);
    error_d       = (state_d == ERROR);
    if (state_d == SHIFT) begin
      data_out_d = shreg_d[7];
    end else if ((state_d == WAIT_BYTE) || (state_d == WAIT_END)) begin
      data_out_d = data_out_q;
    end else begin
      data_out_d = 1'b0;
    end
  end

  assign data_out    = data_out_q;
  assign load_params = load_params_q;
  assign byte_ready  = byte_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign bit_count   = bit_count_q;

endmodule

// File: doc/param_stream_tx.md
# param_stream_tx

Host-side serial transmitter for the network parameter/weight load interface: it accepts parameter bytes over a valid/ready port and serializes them, one acknowledged bit at a time, onto the single-bit stream that feeds the on-chip parallel-out parameter memory. It drives the load request, advances on each per-bit written acknowledge, and closes the transfer on the memory's end-of-writing flag. It lives in the test/FPGA harness and loads the full 312-bit image: 216 weight bits followed by 96 neuron-parameter bits.

## Interface
- NUM_BITS, 312, total bits per transfer; must be a multiple of 8
- TIMEOUT, 255, max cycles to wait for any single acknowledge (used only with the timeout feature)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; ignored while busy
- byte_in  in  8  next parameter byte; first byte carries image bits [311:304]
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  transmitter accepts a byte this cycle
- data_out  out  1  serial bit to the memory's serial input
- load_params  out  1  load request to the memory control unit
- data_written  in  1  memory acknowledge: the current bit was written
- end_writing  in  1  memory flag: the image is complete
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky protocol error flag
- bit_count  out  9  number of bits acknowledged in the current transfer

## Operation
- The state machine has six states: IDLE, LOAD, WAIT_BYTE, SHIFT, WAIT_END and ERROR.
- IDLE
  - On start, clear error and bit_count, then go to LOAD.
- LOAD
  - Assert load_params for exactly this one cycle, then go to WAIT_BYTE.
- WAIT_BYTE
  - byte_ready=1.
  - On byte_valid && byte_ready, capture byte_in into an 8-bit shift register and go to SHIFT.
- SHIFT
  - data_out = shreg[7].
  - On data_written: shift left, increment bit_count and the in-byte counter.
  - If bit_count reaches NUM_BITS, go to WAIT_END.
  - Otherwise, after the 8th bit of a byte, go to WAIT_BYTE.
  - Otherwise stay in SHIFT and present the next bit.
- WAIT_END
  - On end_writing, pulse done and go to IDLE.
- ERROR
  - error=1. Stay until start, which clears error and enters LOAD.
- Bit order: MSB of each byte first, bytes in image order (bit 311 first, bit 0 last).
- Error conditions:
  - end_writing seen in LOAD, WAIT_BYTE or SHIFT → ERROR.
  - data_written seen outside SHIFT (except IDLE) → ERROR.
- busy = 1 in LOAD, WAIT_BYTE, SHIFT and WAIT_END.
- data_out holds its value between acknowledges. It is 0 in IDLE, LOAD and ERROR, and holds the last bit in WAIT_BYTE and WAIT_END.

## Timing
- Reset values:
  - state IDLE.
  - data_out=0, load_params=0, byte_ready=0, busy=0, done=0, error=0, bit_count=0, shift register 0.
- Reset mid-transfer aborts immediately; the next cycle is IDLE with all outputs at reset values.
- Latencies:
  - start in cycle N → load_params=1 in cycle N+1 → byte_ready=1 in cycle N+2.
  - Byte accepted in cycle M → its MSB on data_out in cycle M+1.
- Each bit stays on data_out until the cycle in which data_written=1 is sampled. The next bit appears the following cycle, so at most one bit is acknowledged per cycle.
- After the 8th acknowledge of a byte, byte_ready rises the next cycle. Minimum per-byte overhead is one cycle.
- Simultaneous events:
  - data_written and end_writing on the final bit: count the bit, go to WAIT_END, then take end_writing on its next assertion.
  - end_writing asserted in the same cycle as a non-final acknowledge → ERROR, and the bit is still counted.
- done is high exactly one cycle; busy falls in that same cycle.
- bit_count saturates at NUM_BITS and holds until the next start.

## Configuration
- PARAM_TX_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles spent in SHIFT (awaiting data_written) or WAIT_END (awaiting end_writing).
  - It resets on each acknowledge.
  - Reaching TIMEOUT → ERROR.
- PARAM_TX_TIMEOUT_EN undefined:
  - No watchdog; the block waits indefinitely.
  - The only error sources are the protocol violations listed under Operation.

## Test plan
- Full load:
  - Stimulus: start, feed 39 bytes 0xA5…, memory model acks each bit 1 cycle after presentation, end_writing asserted 2 cycles after the 312th ack.
  - Response: serial stream equals the image MSB-first, load_params exactly 1 pulse, bit_count=312, done one pulse, error=0.
- Back-pressure:
  - Stimulus: byte_valid held low for 10 cycles between bytes.
  - Response: data_out holds its last bit, no extra acks counted, the stream is unchanged.
- Early end:
  - Stimulus: end_writing asserted after the 100th ack.
  - Response: ERROR, error=1, busy=0.
  - Follow-up: a new start clears error and emits a fresh load_params.
- Spurious ack: data_written=1 during WAIT_BYTE → error=1.
- Reset mid-transfer:
  - Stimulus: reset after 50 acks.
  - Response: next cycle all outputs at reset values; a subsequent start completes normally.
- Timeout (PARAM_TX_TIMEOUT_EN defined): ack withheld 255 cycles in SHIFT → error=1; when undefined, no error after 1000 cycles.
